// File: rtl/regfile_shift_unit_pkg.sv
// Shared constants and types for the RV64 register-file / shifter slice.
//   XLEN       : datapath width
//   NREG       : architectural register count
//   REG_AW     : register index width
//   shift_op_e : shifter operation select
package regfile_shift_unit_pkg;

    localparam int XLEN   = 64;
    localparam int NREG   = 32;
    localparam int REG_AW = $clog2(NREG);
    localparam int SHW    = $clog2(XLEN);

    typedef enum logic [1:0] {
        SH_SLL  = 2'b00,
        SH_SRL  = 2'b01,
        SH_SRA  = 2'b10,
        SH_PASS = 2'b11
    } shift_op_e;

endpackage

// File: rtl/regfile_shift_unit_shifter64.sv
// Combinational 64-bit barrel shifter.
//   data_i   : operand
//   amt_i    : shift amount 0..63
//   op_i     : SLL / SRL / SRA / PASS
//   result_o : shifted operand
module shifter64
    import regfile_shift_unit_pkg::*;
(
    input  logic [XLEN-1:0] data_i,
    input  logic [SHW-1:0]  amt_i,
    input  shift_op_e       op_i,
    output logic [XLEN-1:0] result_o
);

    always_comb begin
        result_o = data_i;
        unique case (op_i)
            SH_SLL:  result_o = data_i << amt_i;
            SH_SRL:  result_o = data_i >> amt_i;
            SH_SRA:  result_o = $signed(data_i) >>> amt_i;
            SH_PASS: result_o = data_i;
            default: result_o = data_i;
        endcase
    end

endmodule

// File: rtl/regfile_shift_unit.sv
// RV64 integer datapath slice: 32x64 register file (2 read, 1 write),
// immediate shamt extraction and a barrel shifter on read port 1.
//   Clk, Reset            : clock, synchronous active-high reset
//   RegWrite, WriteReg,
//   WriteData             : write port (x0 writes discarded)
//   ReadReg1/2, ReadData1/2 : combinational read ports, no write bypass
//   Inst, ShiftCtrl       : instruction word (shamt = Inst[25:20]), shift op
//   ShiftN, ShiftOut      : extracted shamt, shift result of ReadData1
module regfile_shift_unit
    import regfile_shift_unit_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              RegWrite,
    input  logic [REG_AW-1:0] ReadReg1,
    input  logic [REG_AW-1:0] ReadReg2,
    input  logic [REG_AW-1:0] WriteReg,
    input  logic [XLEN-1:0]   WriteData,
    input  logic [31:0]       Inst,
    input  logic [1:0]        ShiftCtrl,
    output logic [XLEN-1:0]   ReadData1,
    output logic [XLEN-1:0]   ReadData2,
    output logic [SHW-1:0]    ShiftN,
    output logic [XLEN-1:0]   ShiftOut
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];

    always_comb begin
        regs_d = regs_q;
        if (RegWrite && (WriteReg != '0)) begin
            regs_d[WriteReg] = WriteData;
        end
    end

    // Reset dominates any write in the same cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // x0 is forced to zero on read so it holds even before the first reset.
    assign ReadData1 = (ReadReg1 == '0) ? '0 : regs_q[ReadReg1];
    assign ReadData2 = (ReadReg2 == '0) ? '0 : regs_q[ReadReg2];

    assign ShiftN = Inst[25:20];

    shifter64 u_shifter (
        .data_i   (ReadData1),
        .amt_i    (ShiftN),
        .op_i     (shift_op_e'(ShiftCtrl)),
        .result_o (ShiftOut)
    );

endmodule

// File: tb/tb_regfile_shift_unit.sv
module tb_regfile_shift_unit;

    logic        Clk = 1'b0;
    logic        Reset, RegWrite;
    logic [4:0]  ReadReg1, ReadReg2, WriteReg;
    logic [63:0] WriteData;
    logic [31:0] Inst;
    logic [1:0]  ShiftCtrl;
    logic [63:0] ReadData1, ReadData2, ShiftOut;
    logic [5:0]  ShiftN;

    always #5 Clk = ~Clk;

    regfile_shift_unit dut (
        .Clk(Clk), .Reset(Reset), .RegWrite(RegWrite),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .WriteReg(WriteReg),
        .WriteData(WriteData), .Inst(Inst), .ShiftCtrl(ShiftCtrl),
        .ReadData1(ReadData1), .ReadData2(ReadData2),
        .ShiftN(ShiftN), .ShiftOut(ShiftOut)
    );

    typedef struct {
        string       tag;
        int          sel;   // 0 rd1, 1 rd2, 2 shiftn, 3 shiftout
        logic [63:0] val;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad   = 0;
    logic [63:0] mreg [32];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input int sel, input logic [63:0] v);
        exp_t e;
        e.tag = tag; e.sel = sel; e.val = v;
        sbq.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            case (e.sel)
                0:       chk(e.tag, ReadData1, e.val);
                1:       chk(e.tag, ReadData2, e.val);
                2:       chk(e.tag, {58'd0, ShiftN}, e.val);
                default: chk(e.tag, ShiftOut, e.val);
            endcase
        end
    endtask

    // Bit-by-bit reference shifter.
    function automatic logic [63:0] ref_shift(input logic [63:0] d, input int n, input int op);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) begin
            case (op)
                0:       r[i] = (i >= n) ? d[i-n] : 1'b0;
                1:       r[i] = (i + n < 64) ? d[i+n] : 1'b0;
                2:       r[i] = (i + n < 64) ? d[i+n] : d[63];
                default: r[i] = d[i];
            endcase
        end
        return r;
    endfunction

    // Drive one write (optionally with reset) across a rising edge, update the model.
    task automatic do_write(input logic [4:0] idx, input logic [63:0] data, input logic rst);
        RegWrite  = 1'b1;
        WriteReg  = idx;
        WriteData = data;
        Reset     = rst;
        @(posedge Clk);
        #1;
        if (rst) begin
            for (int i = 0; i < 32; i++) mreg[i] = '0;
        end else if (idx != 0) begin
            mreg[idx] = data;
        end
        RegWrite = 1'b0;
        Reset    = 1'b0;
    endtask

    // Load reg1, select shamt/op, check against fixed expectation and the model.
    task automatic sh_case(input string tag, input logic [63:0] v, input logic [5:0] amt,
                           input logic [1:0] op, input logic [63:0] want);
        do_write(5'd1, v, 1'b0);
        ReadReg1  = 5'd1;
        Inst      = {6'b0, amt, 20'h00000};
        ShiftCtrl = op;
        #1;
        push({tag, "_n"}, 2, {58'd0, amt});
        push(tag, 3, want);
        push({tag, "_ref"}, 3, ref_shift(mreg[1], int'(amt), int'(op)));
        drain();
    endtask

    initial begin
        logic [31:0] rinst;
        logic [4:0]  ridx;
        logic [63:0] rdata;
        logic [5:0]  ramt;

        Reset = 1'b1; RegWrite = 1'b0; ReadReg1 = '0; ReadReg2 = '0;
        WriteReg = '0; WriteData = '0; Inst = '0; ShiftCtrl = '0;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        for (int i = 0; i < 32; i++) mreg[i] = '0;

        // Reset state
        ReadReg1 = 5'd5; ReadReg2 = 5'd31;
        #1;
        push("rst_rd1", 0, 64'd0);
        push("rst_rd2", 1, 64'd0);
        drain();

        // Write timing: old value before edge, new value after
        ReadReg1 = 5'd3; ReadReg2 = 5'd3;
        RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 64'h1122334455667788;
        #1;
        push("wr_before", 0, 64'd0);
        drain();
        do_write(5'd3, 64'h1122334455667788, 1'b0);
        push("wr_after_rd1", 0, 64'h1122334455667788);
        push("wr_after_rd2", 1, 64'h1122334455667788);
        drain();

        // x0 hardwire
        do_write(5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        ReadReg1 = 5'd0; ReadReg2 = 5'd3;
        #1;
        push("x0_read", 0, 64'd0);
        push("x0_other", 1, 64'h1122334455667788);
        drain();

        // Reset beats a simultaneous write
        do_write(5'd4, 64'hA5A5_A5A5_0000_1111, 1'b0);
        ReadReg1 = 5'd4;
        #1;
        push("r4_set", 0, 64'hA5A5_A5A5_0000_1111);
        drain();
        do_write(5'd4, 64'h1234_5678_9ABC_DEF0, 1'b1);
        ReadReg1 = 5'd4; ReadReg2 = 5'd3; ShiftCtrl = 2'b11;
        #1;
        push("rstwr_r4", 0, 64'd0);
        push("rstwr_r3", 1, 64'd0);
        push("rstwr_sh", 3, 64'd0);
        drain();

        // Directed shifts
        sh_case("sll63",  64'h1,                 6'd63, 2'b00, 64'h8000_0000_0000_0000);
        sh_case("srl4",   64'h8000_0000_0000_0000, 6'd4, 2'b01, 64'h0800_0000_0000_0000);
        sh_case("sra4",   64'h8000_0000_0000_0000, 6'd4, 2'b10, 64'hF800_0000_0000_0000);
        sh_case("sll0",   64'h8123_4567_89AB_CDEF, 6'd0, 2'b00, 64'h8123_4567_89AB_CDEF);
        sh_case("srl0",   64'h8123_4567_89AB_CDEF, 6'd0, 2'b01, 64'h8123_4567_89AB_CDEF);
        sh_case("sra0",   64'h8123_4567_89AB_CDEF, 6'd0, 2'b10, 64'h8123_4567_89AB_CDEF);
        sh_case("pass37", 64'hDEADBEEFCAFEF00D,    6'd37, 2'b11, 64'hDEADBEEFCAFEF00D);
        sh_case("sra63",  64'h8000_0000_0000_0000, 6'd63, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF);
        sh_case("srl63",  64'h8000_0000_0000_0000, 6'd63, 2'b01, 64'h1);
        sh_case("sra_pos", 64'h4000_0000_0000_0000, 6'd62, 2'b10, 64'h1);

        // funct6 ignored, shamt all ones
        Inst = 32'hFFFF_FFFF; ShiftCtrl = 2'b11;
        #1;
        push("shamt_ff", 2, 64'h3F);
        drain();

        // Random writes, reads and shifts against the model
        for (int k = 0; k < 40; k++) begin
            ridx  = 5'($urandom_range(0, 31));
            rdata = {$urandom, $urandom};
            do_write(ridx, rdata, 1'b0);
            ReadReg1  = 5'($urandom_range(0, 31));
            ReadReg2  = ridx;
            rinst     = $urandom;
            ramt      = rinst[25:20];
            Inst      = rinst;
            ShiftCtrl = 2'($urandom_range(0, 3));
            #1;
            push("rnd_rd1", 0, mreg[ReadReg1]);
            push("rnd_rd2", 1, mreg[ridx]);
            push("rnd_n",   2, {58'd0, ramt});
            push("rnd_sh",  3, ref_shift(mreg[ReadReg1], int'(ramt), int'(ShiftCtrl)));
            drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
